// File: rtl/alu_exec_pkg.sv
// Shared opcodes, flag indices, FSM states and opcode helpers for the alu execution unit.
// Optional feature: ALU_EXEC_CMP_EN adds CMP/TEST (flags-only compare ops).
package alu_exec_pkg;

   localparam int unsigned OPW = 5;
   localparam int unsigned FLW = 6;

   localparam logic [OPW-1:0] OP_INC  = 5'b00001;
   localparam logic [OPW-1:0] OP_DEC  = 5'b00011;
   localparam logic [OPW-1:0] OP_ADD  = 5'b00100;
   localparam logic [OPW-1:0] OP_ADC  = 5'b00101;
   localparam logic [OPW-1:0] OP_SUB  = 5'b00110;
   localparam logic [OPW-1:0] OP_SBB  = 5'b00111;
   localparam logic [OPW-1:0] OP_AND  = 5'b01000;
   localparam logic [OPW-1:0] OP_OR   = 5'b01001;
   localparam logic [OPW-1:0] OP_XOR  = 5'b01010;
   localparam logic [OPW-1:0] OP_NOT  = 5'b01011;
   localparam logic [OPW-1:0] OP_SHL  = 5'b10000;
   localparam logic [OPW-1:0] OP_SHR  = 5'b10001;
   localparam logic [OPW-1:0] OP_SAL  = 5'b10010;
   localparam logic [OPW-1:0] OP_SAR  = 5'b10011;
   localparam logic [OPW-1:0] OP_ROL  = 5'b10100;
   localparam logic [OPW-1:0] OP_ROR  = 5'b10101;
   localparam logic [OPW-1:0] OP_RCL  = 5'b10110;
   localparam logic [OPW-1:0] OP_RCR  = 5'b10111;
   localparam logic [OPW-1:0] OP_CMP  = 5'b01100;
   localparam logic [OPW-1:0] OP_TEST = 5'b01101;

   localparam int unsigned FLG_C = 5;
   localparam int unsigned FLG_Z = 4;
   localparam int unsigned FLG_N = 3;
   localparam int unsigned FLG_V = 2;
   localparam int unsigned FLG_P = 1;
   localparam int unsigned FLG_A = 0;

   typedef enum logic [1:0] {StIdle, StExec, StWb, StResp} exec_state_e;

   function automatic logic is_legal_op(input logic [OPW-1:0] op);
      logic ok;
      ok = (op == OP_INC) || (op >= OP_DEC && op <= OP_NOT) || (op[4:3] == 2'b10);
`ifdef ALU_EXEC_CMP_EN
      ok = ok || (op == OP_CMP) || (op == OP_TEST);
`endif
      return ok;
   endfunction

   // F code actually presented to the alu; compare ops borrow SUB/AND.
   function automatic logic [OPW-1:0] alu_code(input logic [OPW-1:0] op);
      logic [OPW-1:0] f;
      f = op;
`ifdef ALU_EXEC_CMP_EN
      if (op == OP_CMP)  f = OP_SUB;
      if (op == OP_TEST) f = OP_AND;
`endif
      return f;
   endfunction

endpackage

// File: rtl/alu_exec_if.sv
// Command/response handshake bundle between decode and the alu execution unit.
interface alu_exec_if #(
   parameter int unsigned RW = 3,
   parameter int unsigned DW = 16
);
   logic          cmd_valid;
   logic          cmd_ready;
   logic [4:0]    cmd_op;
   logic [RW-1:0] cmd_dst;
   logic [RW-1:0] cmd_src;
   logic          cmd_use_imm;
   logic [DW-1:0] cmd_imm;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_data;
   logic [5:0]    rsp_flags;
   logic          rsp_err;

   modport master (
      output cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_use_imm, cmd_imm, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_data, rsp_flags, rsp_err
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_use_imm, cmd_imm, rsp_ready,
      output cmd_ready, rsp_valid, rsp_data, rsp_flags, rsp_err
   );
endinterface

// File: rtl/alu_regfile.sv
// NREGS x DW register file: two asynchronous read ports, one synchronous write, async clear.
module alu_regfile #(
   parameter int unsigned NREGS = 8,
   parameter int unsigned DW    = 16,
   localparam int unsigned RW   = $clog2(NREGS)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [RW-1:0] ra_addr,
   output logic [DW-1:0] ra_data,
   input  logic [RW-1:0] rb_addr,
   output logic [DW-1:0] rb_data,
   input  logic          we,
   input  logic [RW-1:0] waddr,
   input  logic [DW-1:0] wdata
);

   logic [DW-1:0] mem_q [NREGS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q <= '{default: '0};
      end else if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign ra_data = mem_q[ra_addr];
   assign rb_data = mem_q[rb_addr];

endmodule

// File: rtl/alu_exec_unit.sv
// Sequencer around an external combinational alu: IDLE -> EXEC -> WB -> RESP, carry chained as Cin.
// Optional feature: ALU_EXEC_CMP_EN enables CMP/TEST (flags written, register not written).
module alu_exec_unit
   import alu_exec_pkg::*;
#(
   parameter int unsigned NREGS = 8,
   parameter int unsigned DW    = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   alu_exec_if.slave       bus,
   output logic [DW-1:0]   alu_a,
   output logic [DW-1:0]   alu_b,
   output logic [OPW-1:0]  alu_f,
   output logic            alu_cin,
   input  logic [DW-1:0]   alu_result,
   input  logic [FLW-1:0]  alu_status,
   output logic [FLW-1:0]  flags_q
);

   localparam int unsigned RW = $clog2(NREGS);

   exec_state_e    state_q, state_d;
   logic [RW-1:0]  dst_q;
   logic           legal_q, nowrite_q;
   logic [DW-1:0]  res_q;
   logic [FLW-1:0] stat_q;
   logic [DW-1:0]  rd_a, rd_b;
   logic           accept, cmp_op, wr_en;
   logic           rsp_valid_q, rsp_err_q;
   logic [DW-1:0]  rsp_data_q;
   logic [FLW-1:0] rsp_flags_q;

   assign accept = (state_q == StIdle) && bus.cmd_valid;
   assign wr_en  = (state_q == StWb) && legal_q && !nowrite_q;

   always_comb begin
      cmp_op = 1'b0;
`ifdef ALU_EXEC_CMP_EN
      cmp_op = (bus.cmd_op == OP_CMP) || (bus.cmd_op == OP_TEST);
`endif
   end

   alu_regfile #(
      .NREGS(NREGS),
      .DW   (DW)
   ) u_regfile (
      .clk    (clk),
      .rst_n  (rst_n),
      .ra_addr(bus.cmd_dst),
      .ra_data(rd_a),
      .rb_addr(bus.cmd_src),
      .rb_data(rd_b),
      .we     (wr_en),
      .waddr  (dst_q),
      .wdata  (res_q)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= StIdle;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d       = state_q;
      bus.cmd_ready = 1'b0;
      unique case (state_q)
         StIdle: begin
            bus.cmd_ready = 1'b1;
            if (bus.cmd_valid) state_d = StExec;
         end
         StExec: state_d = StWb;
         StWb:   state_d = StResp;
         StResp: if (bus.rsp_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_a       <= '0;
         alu_b       <= '0;
         alu_f       <= '0;
         alu_cin     <= 1'b0;
         dst_q       <= '0;
         legal_q     <= 1'b0;
         nowrite_q   <= 1'b0;
         res_q       <= '0;
         stat_q      <= '0;
         flags_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_flags_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         if (accept) begin
            alu_a     <= rd_a;
            alu_b     <= bus.cmd_use_imm ? bus.cmd_imm : rd_b;
            alu_f     <= alu_code(bus.cmd_op);
            alu_cin   <= flags_q[FLG_C];
            dst_q     <= bus.cmd_dst;
            legal_q   <= is_legal_op(bus.cmd_op);
            nowrite_q <= cmp_op;
         end
         if (state_q == StExec) begin
            res_q  <= alu_result;
            stat_q <= alu_status;
         end
         if (state_q == StWb) begin
            rsp_valid_q <= 1'b1;
            if (legal_q) begin
               flags_q     <= stat_q;
               rsp_data_q  <= res_q;
               rsp_flags_q <= stat_q;
               rsp_err_q   <= 1'b0;
            end else begin
               // Illegal op: report the untouched architectural flags.
               rsp_data_q  <= '0;
               rsp_flags_q <= flags_q;
               rsp_err_q   <= 1'b1;
            end
         end
         if (state_q == StResp && bus.rsp_ready) rsp_valid_q <= 1'b0;
      end
   end

   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_flags = rsp_flags_q;
   assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit with a behavioural alu attached; reference model tracks regs and flags.
module tb_alu_exec_unit;
   import alu_exec_pkg::*;

   localparam int unsigned NREGS = 8;
   localparam int unsigned DW    = 16;
   localparam int unsigned RW    = 3;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   alu_exec_if #(.RW(RW), .DW(DW)) bus ();

   logic [15:0] alu_a, alu_b, alu_result;
   logic [4:0]  alu_f;
   logic        alu_cin;
   logic [5:0]  alu_status, flags_q;

   alu_exec_unit #(
      .NREGS(NREGS),
      .DW   (DW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_f     (alu_f),
      .alu_cin   (alu_cin),
      .alu_result(alu_result),
      .alu_status(alu_status),
      .flags_q   (flags_q)
   );

   // Behavioural alu: returns {result, C, Z, N, V, P, A}.
   function automatic logic [21:0] alu_model(input logic [15:0] a, input logic [15:0] b,
                                             input logic [4:0] f, input logic cin);
      logic [15:0] res, y;
      logic [16:0] w;
      logic        c, v, ax, ci;
      int          n;
      res = '0; y = b; w = '0; c = 1'b0; v = 1'b0; ax = 1'b0; ci = 1'b0;
      n = int'(b[3:0]);
      case (f)
         5'b00001, 5'b00100, 5'b00101: begin
            y   = (f == 5'b00001) ? 16'd1 : b;
            ci  = (f == 5'b00101) ? cin : 1'b0;
            w   = {1'b0, a} + {1'b0, y} + {16'd0, ci};
            res = w[15:0];
            c   = w[16];
            v   = (a[15] == y[15]) && (res[15] != a[15]);
            ax  = ({1'b0, a[3:0]} + {1'b0, y[3:0]} + {4'd0, ci}) > 5'd15;
         end
         5'b00011, 5'b00110, 5'b00111: begin
            y   = (f == 5'b00011) ? 16'd1 : b;
            ci  = (f == 5'b00111) ? cin : 1'b0;
            w   = {1'b0, a} - {1'b0, y} - {16'd0, ci};
            res = w[15:0];
            c   = w[16];
            v   = (a[15] != y[15]) && (res[15] != a[15]);
            ax  = {1'b0, a[3:0]} < ({1'b0, y[3:0]} + {4'd0, ci});
         end
         5'b01000: res = a & b;
         5'b01001: res = a | b;
         5'b01010: res = a ^ b;
         5'b01011: res = ~a;
         5'b10000, 5'b10010: begin w = {1'b0, a} << n; res = w[15:0]; c = w[16]; end
         5'b10001: begin w = {a, 1'b0} >> n; res = w[16:1]; c = w[0]; end
         5'b10011: begin w = $signed({a, 1'b0}) >>> n; res = w[16:1]; c = w[0]; end
         5'b10100: begin res = a; for (int i = 0; i < n; i++) begin c = res[15]; res = {res[14:0], res[15]}; end end
         5'b10101: begin res = a; for (int i = 0; i < n; i++) begin c = res[0]; res = {res[0], res[15:1]}; end end
         5'b10110: begin res = a; c = cin; for (int i = 0; i < n; i++) {c, res} = {res, c}; end
         5'b10111: begin res = a; c = cin; for (int i = 0; i < n; i++) {res, c} = {c, res}; end
         default: ;
      endcase
      return {res, c, res == 16'd0, res[15], v, ~^res[7:0], ax};
   endfunction

   always_comb {alu_result, alu_status} = alu_model(alu_a, alu_b, alu_f, alu_cin);

   function automatic logic op_ok(input logic [4:0] op);
      logic ok;
      ok = (op == 5'b00001) || (op >= 5'b00011 && op <= 5'b01011) ||
           (op >= 5'b10000 && op <= 5'b10111);
`ifdef ALU_EXEC_CMP_EN
      ok = ok || (op == 5'b01100) || (op == 5'b01101);
`endif
      return ok;
   endfunction

   function automatic logic [4:0] f_of(input logic [4:0] op);
      logic [4:0] f;
      f = op;
`ifdef ALU_EXEC_CMP_EN
      if (op == 5'b01100) f = 5'b00110;
      if (op == 5'b01101) f = 5'b01000;
`endif
      return f;
   endfunction

   function automatic logic flags_only(input logic [4:0] op);
      logic r;
      r = 1'b0;
`ifdef ALU_EXEC_CMP_EN
      r = (op == 5'b01100) || (op == 5'b01101);
`endif
      return r;
   endfunction

   logic [15:0] m_regs [NREGS];
   logic [5:0]  m_flags;
   int          total = 0;
   int          bad = 0;
   logic [15:0] last_data;
   logic [5:0]  last_flags;
   logic        last_err;
   logic        last_cin;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
      m_flags = '0;
   endtask

   task automatic run_cmd(input logic [4:0] op, input logic [2:0] dst, input logic [2:0] src,
                          input logic use_imm, input logic [15:0] imm, input int hold,
                          input logic poke);
      logic [15:0] a, b, exp_data;
      logic [5:0]  exp_flags;
      logic [21:0] r;
      logic        ok;
      int          cnt;
      a  = m_regs[dst];
      b  = use_imm ? imm : m_regs[src];
      ok = op_ok(op);
      r  = alu_model(a, b, f_of(op), m_flags[5]);
      cnt = 0;
      while (!bus.cmd_ready && cnt < 20) begin @(posedge clk); #1; cnt++; end
      check_eq("cmd_ready_idle", bus.cmd_ready, 1);
      bus.cmd_op = op; bus.cmd_dst = dst; bus.cmd_src = src;
      bus.cmd_use_imm = use_imm; bus.cmd_imm = imm; bus.cmd_valid = 1'b1;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      last_cin = alu_cin;
      check_eq("alu_a", alu_a, a);
      check_eq("alu_b", alu_b, b);
      check_eq("alu_cin", alu_cin, m_flags[5]);
      check_eq("cmd_ready_busy", bus.cmd_ready, 0);
      cnt = 1;
      while (!bus.rsp_valid && cnt < 10) begin @(posedge clk); #1; cnt++; end
      check_eq("latency", cnt, 3);
      if (ok) begin
         exp_data  = r[21:6];
         exp_flags = r[5:0];
         if (!flags_only(op)) m_regs[dst] = r[21:6];
         m_flags = r[5:0];
      end else begin
         exp_data  = '0;
         exp_flags = m_flags;
      end
      check_eq("rsp_data", bus.rsp_data, exp_data);
      check_eq("rsp_flags", bus.rsp_flags, exp_flags);
      check_eq("rsp_err", bus.rsp_err, !ok);
      check_eq("flags_q", flags_q, m_flags);
      last_data = bus.rsp_data; last_flags = bus.rsp_flags; last_err = bus.rsp_err;
      for (int i = 0; i < hold; i++) begin
         bus.cmd_valid = poke;
         @(posedge clk); #1;
         check_eq("hold_valid", bus.rsp_valid, 1);
         check_eq("hold_data", bus.rsp_data, exp_data);
         check_eq("hold_flags", bus.rsp_flags, exp_flags);
         check_eq("hold_ready", bus.cmd_ready, 0);
      end
      bus.cmd_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
      check_eq("rsp_drop", bus.rsp_valid, 0);
      check_eq("back_idle", bus.cmd_ready, 1);
   endtask

   initial begin
      bus.cmd_valid = 1'b0; bus.rsp_ready = 1'b0; bus.cmd_op = '0; bus.cmd_dst = '0;
      bus.cmd_src = '0; bus.cmd_use_imm = 1'b0; bus.cmd_imm = '0;
      last_data = '0; last_flags = '0; last_err = 1'b0; last_cin = 1'b0;
      model_reset();
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_cmd_ready", bus.cmd_ready, 1);
      check_eq("rst_rsp_valid", bus.rsp_valid, 0);
      check_eq("rst_rsp_data", bus.rsp_data, 0);
      check_eq("rst_rsp_flags", bus.rsp_flags, 0);
      check_eq("rst_rsp_err", bus.rsp_err, 0);
      check_eq("rst_flags", flags_q, 0);
      check_eq("rst_alu_abf", {alu_a, alu_b, alu_f, alu_cin}, 0);
      @(negedge clk) rst_n = 1'b1;

      // Signed overflow into bit 15.
      run_cmd(5'b00100, 3'd1, 3'd0, 1'b1, 16'h7FFF, 0, 1'b0);
      run_cmd(5'b00100, 3'd1, 3'd0, 1'b1, 16'h0001, 0, 1'b0);
      check_eq("t1_data", last_data, 16'h8000);
      check_eq("t1_czNV", {last_flags[5], last_flags[4], last_flags[3], last_flags[2]}, 4'b0011);
      run_cmd(5'b01001, 3'd1, 3'd0, 1'b1, 16'h0000, 0, 1'b0);
      check_eq("t1_r1", last_data, 16'h8000);

      // Carry out chained into ADC.
      run_cmd(5'b00100, 3'd2, 3'd0, 1'b1, 16'hFFFF, 0, 1'b0);
      check_eq("t2_ffff", last_data, 16'hFFFF);
      run_cmd(5'b00100, 3'd2, 3'd0, 1'b1, 16'h0001, 0, 1'b0);
      check_eq("t2_zero", last_data, 16'h0000);
      check_eq("t2_cz", last_flags[5:4], 2'b11);
      run_cmd(5'b00101, 3'd3, 3'd0, 1'b1, 16'h0000, 0, 1'b0);
      check_eq("t2_cin", last_cin, 1);
      check_eq("t2_r3", last_data, 16'h0001);

      // Illegal opcodes.
      run_cmd(5'b00000, 3'd1, 3'd2, 1'b0, 16'h1111, 0, 1'b0);
      check_eq("t3_err0", last_err, 1);
      run_cmd(5'b11000, 3'd1, 3'd2, 1'b1, 16'h2222, 0, 1'b0);
      check_eq("t3_err1", last_err, 1);
      check_eq("t3_data", last_data, 0);

      // Back-pressure with a competing command offered.
      run_cmd(5'b00100, 3'd7, 3'd0, 1'b1, 16'h0011, 5, 1'b1);

      // Rotate right by 10.
      run_cmd(5'b01001, 3'd4, 3'd0, 1'b1, 16'h0082, 0, 1'b0);
      run_cmd(5'b10101, 3'd4, 3'd0, 1'b1, 16'h000A, 0, 1'b0);
      check_eq("t5_ror", last_data, 16'h2080);

      // Reset in the middle of EXEC.
      bus.cmd_op = 5'b00100; bus.cmd_dst = 3'd5; bus.cmd_use_imm = 1'b1;
      bus.cmd_imm = 16'h1234; bus.cmd_valid = 1'b1;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_eq("t6_rsp_valid", bus.rsp_valid, 0);
      check_eq("t6_cmd_ready", bus.cmd_ready, 1);
      check_eq("t6_flags", flags_q, 0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_eq("t6_no_rsp", bus.rsp_valid, 0);
      run_cmd(5'b01001, 3'd5, 3'd0, 1'b1, 16'h0000, 0, 1'b0);
      check_eq("t6_r5", last_data, 16'h0000);

      // Random commands over the whole opcode space.
      for (int k = 0; k < 200; k++) begin
         run_cmd(5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 16'($urandom), $urandom_range(0, 3), 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
